multicycle_ctrl: RTL and testbench

- Moore/Mealy control FSM that sequences the multi-cycle CPU datapath through the IF, ID, EXE, MEM and WB phases.
- Inputs are the IR opcode (decode) and the ALU zero flag.
- Drives every datapath control strobe, including PC, IR, register-file and data-memory write enables and all mux selects.
- The PC is written exactly once per instruction, in that instruction's final state.

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives every
// datapath strobe. Outputs are combinational from state, opcode and zero.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] decode,
    input  logic            zero,
    output logic            PCWre,
    output logic            IRWre,
    output logic            RegWre,
    output logic            DataMemRw,
    output logic            InsMemRW,
    output logic            ALUSrcB,
    output logic            ExtSel,
    output logic            SAExt,
    output logic            ALUM2Reg,
    output logic            WrRegData,
    output logic [1:0]      RegOut,
    output logic [1:0]      PCSrc,
    output logic [2:0]      ALUOp,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt,
`endif
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_EXE_BR = 4'b0011,
        S_EXE_LS = 4'b0100,
        S_MEM    = 4'b0101,
        S_WB_AL  = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    localparam logic [OP_W-1:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
    localparam logic [OP_W-1:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    state_e state_q, state_d;
    logic   is_imm;

    assign state    = state_q;
    assign InsMemRW = 1'b1;
    assign is_imm   = (decode == OP_ADDI) || (decode == OP_ORI) || (decode == OP_SLTI);

    // State register; reset drops straight back to IF
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Next-state and control strobes; write enables are gated by reset so
    // nothing partially commits once reset rises mid-instruction
    always_comb begin
        state_d   = S_IF;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        DataMemRw = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        SAExt     = 1'b0;
        ALUM2Reg  = 1'b0;
        WrRegData = 1'b0;
        RegOut    = 2'b00;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (decode)
                    OP_J:    begin PCWre = 1'b1; PCSrc = 2'b11; end
                    OP_JR:   begin PCWre = 1'b1; PCSrc = 2'b10; end
                    OP_JAL:  begin RegWre = 1'b1; PCWre = 1'b1; PCSrc = 2'b11; end
                    OP_HALT: state_d = S_HALT;
                    OP_BEQ:  state_d = S_EXE_BR;
                    OP_LW, OP_SW: state_d = S_EXE_LS;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                    OP_SLL, OP_SLT, OP_SLTI: state_d = S_EXE_AL;
                    default: PCWre = 1'b1;  // undefined opcode retires as a NOP
                endcase
            end
            S_EXE_AL: begin
                state_d = S_WB_AL;
                ALUSrcB = is_imm || (decode == OP_SLL);
                ExtSel  = (decode == OP_ADDI) || (decode == OP_SLTI);
                SAExt   = (decode == OP_SLL);
                case (decode)
                    OP_SUB:          ALUOp = 3'b001;
                    OP_SLT, OP_SLTI: ALUOp = 3'b010;
                    OP_OR, OP_ORI:   ALUOp = 3'b011;
                    OP_AND:          ALUOp = 3'b100;
                    OP_SLL:          ALUOp = 3'b101;
                    default:         ALUOp = 3'b000;
                endcase
            end
            S_WB_AL: begin
                RegWre    = 1'b1;
                WrRegData = 1'b1;
                PCWre     = 1'b1;
                RegOut    = is_imm ? 2'b01 : 2'b10;
            end
            S_EXE_BR: begin
                ALUOp  = 3'b001;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = zero ? 2'b01 : 2'b00;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                // keep the address operands steady so ALUOut does not move
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (decode == OP_SW) begin
                    DataMemRw = 1'b1;
                    PCWre     = 1'b1;
                end else if (decode == OP_LW) begin
                    ALUM2Reg = 1'b1;
                    state_d  = S_WB_LD;
                end
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                RegOut    = 2'b01;
                WrRegData = 1'b1;
                PCWre     = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;  // illegal encodings recover with no enables
        endcase
        if (reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            RegWre    = 1'b0;
            DataMemRw = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

    // Counter next values: running cycles outside HALT, retired instructions
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (PCWre)             instr_cnt_d = instr_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset and free to wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; expected values are hand-computed.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] decode = 6'b000000;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, RegWre, DataMemRw, InsMemRW, ALUSrcB, ExtSel, SAExt;
    logic       ALUM2Reg, WrRegData;
    logic [1:0] RegOut, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .decode(decode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .DataMemRw(DataMemRw),
        .InsMemRW(InsMemRW), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .SAExt(SAExt),
        .ALUM2Reg(ALUM2Reg), .WrRegData(WrRegData), .RegOut(RegOut), .PCSrc(PCSrc),
        .ALUOp(ALUOp),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    // {PCWre,IRWre,RegWre,DataMemRw,ALUSrcB,ExtSel,SAExt,ALUM2Reg,WrRegData,RegOut,PCSrc,ALUOp}
    logic [15:0] ctrl;
    assign ctrl = {PCWre, IRWre, RegWre, DataMemRw, ALUSrcB, ExtSel, SAExt, ALUM2Reg,
                   WrRegData, RegOut, PCSrc, ALUOp};

    function automatic logic [15:0] cv(input logic pc, ir, rw, dm, sb, ex, sa, m2r, wrd,
                                       input logic [1:0] ro, ps, input logic [2:0] op);
        return {pc, ir, rw, dm, sb, ex, sa, m2r, wrd, ro, ps, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // check state and full strobe vector together
    task automatic chks(input string tag, input logic [3:0] st, input logic [15:0] c);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
        chk({tag, ".ctrl"}, {16'd0, ctrl}, {16'd0, c});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] C_IF   = 16'b0100_0000_0_00_00_000;
    localparam logic [15:0] C_ZERO = 16'd0;

    // ALU op table: opcode, expected EXE_AL strobes, expected WB_AL RegOut
    logic [5:0]  alu_op [6] = '{6'b000010, 6'b011000, 6'b010010, 6'b100111, 6'b000001, 6'b010001};
    logic [15:0] alu_exe[6];
    logic [1:0]  alu_ro [6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};

    initial begin
        alu_exe[0] = cv(0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b000); // addi
        alu_exe[1] = cv(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b101); // sll
        alu_exe[2] = cv(0,0,0,0,1,0,0,0,0,2'b00,2'b00,3'b011); // ori
        alu_exe[3] = cv(0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b010); // slti
        alu_exe[4] = cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b001); // sub
        alu_exe[5] = cv(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b100); // and

        // reset: state IF, IRWre forced low, InsMemRW high
        #2;
        chks("reset", 4'h0, C_ZERO);
        chk("insmemrw", {31'd0, InsMemRW}, 32'd1);
        #10 reset = 1'b0;  // released mid-cycle (t=12)
        #1;

        // add: IF ID EXE_AL WB_AL IF
        chks("add.if", 4'h0, C_IF);
        tick(); chks("add.id", 4'h1, C_ZERO);
        tick(); chks("add.exe", 4'h2, C_ZERO);
        tick(); chks("add.wb", 4'h6, cv(1,0,1,0,0,0,0,0,1,2'b10,2'b00,3'b000));
        tick(); chks("add.end", 4'h0, C_IF);

        // other ALU ops
        for (int i = 0; i < 6; i++) begin
            decode = alu_op[i];
            tick(); chks("alu.id", 4'h1, C_ZERO);
            tick(); chks("alu.exe", 4'h2, alu_exe[i]);
            tick(); chks("alu.wb", 4'h6, cv(1,0,1,0,0,0,0,0,1,alu_ro[i],2'b00,3'b000));
            tick(); chks("alu.end", 4'h0, C_IF);
        end

        // lw: 5 cycles
        decode = 6'b110001;
        tick(); chks("lw.id", 4'h1, C_ZERO);
        tick(); chks("lw.exe", 4'h4, cv(0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b000));
        tick(); chks("lw.mem", 4'h5, cv(0,0,0,0,1,1,0,1,0,2'b00,2'b00,3'b000));
        tick(); chks("lw.wb", 4'h7, cv(1,0,1,0,0,0,0,0,1,2'b01,2'b00,3'b000));
        tick(); chks("lw.end", 4'h0, C_IF);

        // sw: 4 cycles, DataMemRw only in MEM
        decode = 6'b110000;
        tick(); chks("sw.id", 4'h1, C_ZERO);
        tick(); chks("sw.exe", 4'h4, cv(0,0,0,0,1,1,0,0,0,2'b00,2'b00,3'b000));
        tick(); chks("sw.mem", 4'h5, cv(1,0,0,1,1,1,0,0,0,2'b00,2'b00,3'b000));
        tick(); chks("sw.end", 4'h0, C_IF);

        // beq taken and not taken
        decode = 6'b110100; zero = 1'b1;
        tick(); chks("beq1.id", 4'h1, C_ZERO);
        tick(); chks("beq1.exe", 4'h3, cv(1,0,0,0,0,1,0,0,0,2'b00,2'b01,3'b001));
        zero = 1'b0; #1;
        chks("beq.mealy", 4'h3, cv(1,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b001));
        tick(); chks("beq0.end", 4'h0, C_IF);
        tick(); chks("beq0.id", 4'h1, C_ZERO);
        tick(); chks("beq0.exe", 4'h3, cv(1,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b001));
        tick(); chks("beq0.end2", 4'h0, C_IF);

        // jal, jr, j, undefined opcode: 2 cycles each
        decode = 6'b111010;
        tick(); chks("jal.id", 4'h1, cv(1,0,1,0,0,0,0,0,0,2'b00,2'b11,3'b000));
        tick(); chks("jal.end", 4'h0, C_IF);
        decode = 6'b111001;
        tick(); chks("jr.id", 4'h1, cv(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000));
        tick(); chks("jr.end", 4'h0, C_IF);
        decode = 6'b111000;
        tick(); chks("j.id", 4'h1, cv(1,0,0,0,0,0,0,0,0,2'b00,2'b11,3'b000));
        tick(); chks("j.end", 4'h0, C_IF);
        decode = 6'b101010;
        tick(); chks("nop.id", 4'h1, cv(1,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000));
        tick(); chks("nop.end", 4'h0, C_IF);

        // halt: held 20 cycles, then asynchronous reset
        decode = 6'b111111;
        tick(); chks("halt.id", 4'h1, C_ZERO);
        for (int i = 0; i < 20; i++) begin
            tick(); chks("halt.hold", 4'h8, C_ZERO);
        end
        #2 reset = 1'b1;
        #1 chks("halt.areset", 4'h0, C_ZERO);
        #1 reset = 1'b0;  // still before the next edge
        #1;

        // reset during MEM of sw
        decode = 6'b110000;
        chks("swr.if", 4'h0, C_IF);
        tick(); tick(); tick();
        chk("swr.mem.dm", {31'd0, DataMemRw}, 32'd1);
        #1 reset = 1'b1;
        #1 chk("swr.dm_drop", {31'd0, DataMemRw}, 32'd0);
        chk("swr.state", {28'd0, state}, 32'd0);
        chk("swr.pcwre", {31'd0, PCWre}, 32'd0);
        #1 reset = 1'b0;
        #1;

`ifdef MULTICYCLE_CTRL_PERF_EN
        // two adds from a fresh reset: 8 cycles, 2 instructions
        decode = 6'b000000;
        chk("perf.cyc0", cycle_cnt, 32'd0);
        chk("perf.ins0", instr_cnt, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("perf.cyc", cycle_cnt, 32'd8);
        chk("perf.ins", instr_cnt, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
